// File: rtl/fp32_to_bf16_conv.sv
// FP32 -> BF16 narrowing converter with round-to-nearest-even, a two-stage
// valid/ready pipeline and sticky exception flags for software readback.
module fp32_to_bf16_conv #(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        flag_clr,
  output logic        flag_inexact,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_invalid
);

  localparam int unsigned MAG_W = 15;
  localparam int unsigned EXP_W = 8;

  typedef enum logic [1:0] {
    CLS_FIN,
    CLS_FLUSH,
    CLS_INF,
    CLS_NAN
  } cls_e;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic             round_up;
    logic             inexact;
    logic             snan;
    cls_e             cls;
  } s1_t;

  logic             s1_valid;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             s2_ready;
  logic [MAG_W-1:0] sum;
  logic [15:0]      res;
  logic             res_inexact;
  logic             res_overflow;
  logic             res_underflow;
  logic             res_invalid;
  logic             s2_inexact;
  logic             s2_overflow;
  logic             s2_underflow;
  logic             s2_invalid;
  logic             out_fire;

  assign s2_ready = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_ready;
  assign out_fire = out_valid & out_ready;

  // Stage 1 decode: classify the operand and take the RNE decision.
  always_comb begin
    s1_d.sign     = in_data[31];
    s1_d.mag      = in_data[30:16];
    s1_d.round_up = in_data[15] & ((|in_data[14:0]) | in_data[16]);
    s1_d.inexact  = in_data[15] | (|in_data[14:0]);
    s1_d.snan     = ~in_data[22];
    s1_d.cls      = CLS_FIN;
    if (in_data[30:23] == {EXP_W{1'b1}}) begin
      s1_d.cls = (in_data[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
    end else if (FLUSH_DENORM && (in_data[30:23] == '0) && (in_data[22:0] != 23'h0)) begin
      s1_d.cls = CLS_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '{sign: 1'b0, mag: '0, round_up: 1'b0, inexact: 1'b0,
                    snan: 1'b0, cls: CLS_FIN};
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2 compute: the 15-bit add lets a mantissa carry bump the exponent.
  always_comb begin
    sum           = s1_q.mag + MAG_W'(s1_q.round_up);
    res           = {s1_q.sign, sum};
    res_inexact   = 1'b0;
    res_overflow  = 1'b0;
    res_underflow = 1'b0;
    res_invalid   = 1'b0;
    case (s1_q.cls)
      CLS_FIN: begin
        res_inexact   = s1_q.inexact;
        res_overflow  = (sum[14:7] == {EXP_W{1'b1}});
        res_underflow = s1_q.inexact & (sum[14:7] == '0);
      end
      CLS_FLUSH: begin
        res           = {s1_q.sign, 15'h0000};
        res_inexact   = 1'b1;
        res_underflow = 1'b1;
      end
      CLS_INF: res = {s1_q.sign, 8'hFF, 7'h00};
      default: begin
        res         = {s1_q.sign, 8'hFF, 7'h40};
        res_invalid = s1_q.snan;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= 16'h0000;
      s2_inexact   <= 1'b0;
      s2_overflow  <= 1'b0;
      s2_underflow <= 1'b0;
      s2_invalid   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= res;
        s2_inexact   <= res_inexact;
        s2_overflow  <= res_overflow;
        s2_underflow <= res_underflow;
        s2_invalid   <= res_invalid;
      end
    end
  end

  // Sticky flags: a contribution delivered on the same edge as flag_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_inexact   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_invalid   <= 1'b0;
    end else begin
      flag_inexact   <= (flag_inexact   & ~flag_clr) | (out_fire & s2_inexact);
      flag_overflow  <= (flag_overflow  & ~flag_clr) | (out_fire & s2_overflow);
      flag_underflow <= (flag_underflow & ~flag_clr) | (out_fire & s2_underflow);
      flag_invalid   <= (flag_invalid   & ~flag_clr) | (out_fire & s2_invalid);
    end
  end

endmodule

// File: tb/tb_fp32_to_bf16_conv.sv
// Scoreboard bench for fp32_to_bf16_conv: a flushing and a non-flushing
// instance share one input stream; each has its own expected-result queue.
module tb_fp32_to_bf16_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        flag_clr = 1'b0;

  logic        in_ready_a, out_valid_a;
  logic [15:0] out_data_a;
  logic        inx_a, ovf_a, unf_a, inv_a;
  logic        in_ready_b, out_valid_b;
  logic [15:0] out_data_b;
  logic        inx_b, ovf_b, unf_b, inv_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  fp32_to_bf16_conv #(.FLUSH_DENORM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .flag_clr(flag_clr), .flag_inexact(inx_a),
    .flag_overflow(ovf_a), .flag_underflow(unf_a), .flag_invalid(inv_a)
  );

  fp32_to_bf16_conv #(.FLUSH_DENORM(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .flag_clr(flag_clr), .flag_inexact(inx_b),
    .flag_overflow(ovf_b), .flag_underflow(unf_b), .flag_invalid(inv_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare each delivered result against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (q_a.size() == 0) check("unexpected_out_a", {16'h0, out_data_a}, 32'hFFFF_FFFF);
      else check("out_data_a", {16'h0, out_data_a}, {16'h0, q_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b && out_ready) begin
      if (q_b.size() == 0) check("unexpected_out_b", {16'h0, out_data_b}, 32'hFFFF_FFFF);
      else check("out_data_b", {16'h0, out_data_b}, {16'h0, q_b.pop_front()});
    end
  end

  // Present one operand and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [31:0] d, input logic [15:0] ea, input logic [15:0] eb);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      if (acc) begin
        q_a.push_back(ea);
        q_b.push_back(eb);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) return;
      @(posedge clk);
      #1;
    end
    check("drain_timeout", q_a.size() + q_b.size(), 32'h0);
  endtask

  task automatic clr_flags();
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
  endtask

  task automatic check_flags(input string name, input logic [3:0] fa, input logic [3:0] fb);
    check({name, "_flags_a"}, {28'h0, inx_a, ovf_a, unf_a, inv_a}, {28'h0, fa});
    check({name, "_flags_b"}, {28'h0, inx_b, ovf_b, unf_b, inv_b}, {28'h0, fb});
  endtask

  initial begin
    // Flag nibble order: {inexact, overflow, underflow, invalid}
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, out_valid_a}, 32'h0);
    check("reset_out_data", {16'h0, out_data_a}, 32'h0);
    check_flags("reset", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", {31'h0, in_ready_a}, 32'h1);

    // 1.0: accepted on the edge ending its cycle, visible one edge later
    send(32'h3F80_0000, 16'h3F80, 16'h3F80);
    check("lat_s1_only", {31'h0, out_valid_a}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_out_valid", {31'h0, out_valid_a}, 32'h1);
    check("lat_out_data", {16'h0, out_data_a}, 32'h3F80);
    drain();
    check_flags("one", 4'b0000, 4'b0000);

    // RNE ties and rounding
    send(32'h3F80_8000, 16'h3F80, 16'h3F80);
    drain();
    check_flags("tie_even", 4'b1000, 4'b1000);
    send(32'h3F81_8000, 16'h3F82, 16'h3F82);
    send(32'h3F80_8001, 16'h3F81, 16'h3F81);
    drain();

    // Overflow and mantissa carry
    clr_flags();
    check_flags("after_clr", 4'b0000, 4'b0000);
    send(32'h7F7F_FFFF, 16'h7F80, 16'h7F80);
    drain();
    check_flags("overflow", 4'b1100, 4'b1100);
    clr_flags();
    send(32'h3FFF_FFFF, 16'h4000, 16'h4000);
    drain();
    check_flags("carry", 4'b1000, 4'b1000);

    // NaN and infinity
    clr_flags();
    send(32'h7F80_0001, 16'h7FC0, 16'h7FC0);
    drain();
    check_flags("snan", 4'b0001, 4'b0001);
    clr_flags();
    send(32'hFFC0_0000, 16'hFFC0, 16'hFFC0);
    send(32'hFF80_0000, 16'hFF80, 16'hFF80);
    drain();
    check_flags("qnan_inf", 4'b0000, 4'b0000);

    // Denormals: a flushes, b rounds into bf16 denormals
    send(32'h0040_0000, 16'h0000, 16'h0040);
    drain();
    check_flags("denorm_exact", 4'b1010, 4'b0000);
    clr_flags();
    send(32'h0041_8000, 16'h0000, 16'h0042);
    drain();
    check_flags("denorm_round", 4'b1010, 4'b1010);
    clr_flags();
    send(32'h007F_8000, 16'h0000, 16'h0080);
    drain();
    check_flags("denorm_to_norm", 4'b1010, 4'b1000);
    clr_flags();

    // Backpressure: out_ready low for four cycles mid-stream
    fork
      begin
        send(32'h3F80_0000, 16'h3F80, 16'h3F80);
        send(32'h4049_0FDB, 16'h4049, 16'h4049);
        send(32'h8000_0000, 16'h8000, 16'h8000);
        send(32'hC0A0_0000, 16'hC0A0, 16'hC0A0);
        send(32'h3F81_8000, 16'h3F82, 16'h3F82);
        send(32'h7F80_0000, 16'h7F80, 16'h7F80);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall_in_ready", {31'h0, in_ready_a}, 32'h0);
        check("stall_out_valid", {31'h0, out_valid_a}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("pre_reset_inexact", {31'h0, inx_a}, 32'h1);

    // Reset mid-stream drops in-flight data and clears flags at once
    send(32'h3F80_8001, 16'h3F81, 16'h3F81);
    send(32'h4049_0FDB, 16'h4049, 16'h4049);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid_a", {31'h0, out_valid_a}, 32'h0);
    check("rst_out_valid_b", {31'h0, out_valid_b}, 32'h0);
    check_flags("rst_mid", 4'b0000, 4'b0000);
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h3F80_0000, 16'h3F80, 16'h3F80);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", {31'h0, out_valid_a}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
